// File: rtl/bch_syndrome_capture.sv
`default_nettype none
// ============================================================================
// Module   : bch_syndrome_capture
// Purpose  : Counts the ce beats of each BCH codeword and, one cycle after the
//            final beat, snapshots the live syndrome accumulators into a
//            valid/ready output buffer. A completed codeword that finds the
//            buffer still full (and not being drained) is dropped and flagged
//            with a one-cycle overflow pulse.
// Ports    : clk        - sole clock, all state on the rising edge
//            reset      - asynchronous active-high reset
//            start      - beat 0 marker, qualified by ce
//            ce         - beat enable shared with the syndrome accumulators
//            syn_in     - live accumulator outputs, syndrome k at [k*M+:M]
//            busy       - a codeword is being counted or captured
//            syn_valid  - output buffer holds a captured syndrome set
//            syn_ready  - downstream accepts the buffer when valid & ready
//            syn_out    - captured syndromes, stable while syn_valid
//            syn_err    - captured set has a nonzero syndrome
//            overflow   - one-cycle pulse when a completed codeword is dropped
// Revision : 1.0 - initial release
// ============================================================================
module bch_syndrome_capture #(
  parameter int M     = 4,
  parameter int NSYN  = 2,
  parameter int BEATS = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ce,
  input  logic [NSYN*M-1:0] syn_in,
  output logic              busy,
  output logic              syn_valid,
  input  logic              syn_ready,
  output logic [NSYN*M-1:0] syn_out,
  output logic              syn_err,
  output logic              overflow
);

  // BEATS >= 2, so the counter is always at least one bit wide.
  localparam int                c_cnt_w     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(BEATS - 1);
  localparam logic [c_cnt_w-1:0] c_one       = c_cnt_w'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COUNT   = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [c_cnt_w-1:0]  cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic [NSYN*M-1:0]   out_q, out_d;
  logic                err_q, err_d;
  logic                ovf_q, ovf_d;

  logic                w_go;
  logic                w_capture;

  assign w_go      = ce & start;
  assign w_capture = (state_q == S_CAPTURE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      out_q   <= out_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  // Beat counting. The start beat is beat 0, so the counter is loaded with 1
  // on it; the beat seen with the counter at BEATS-1 is the last one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (w_go) begin
          state_d = S_COUNT;
          cnt_d   = c_one;
        end
      end
      S_COUNT: begin
        if (ce) begin
          if (start) begin
            // Restart abandons the partial codeword without a capture.
            cnt_d = c_one;
          end else if (cnt_q == c_last_beat) begin
            state_d = S_CAPTURE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + c_one;
          end
        end
      end
      S_CAPTURE: begin
        // Accumulators are registered, so the final beat's syndromes are
        // only visible now; a new codeword may already begin this cycle.
        if (w_go) begin
          state_d = S_COUNT;
          cnt_d   = c_one;
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output buffer. A capture may overwrite the buffer when it is empty or is
  // being handed off in this very cycle; otherwise the new set is dropped.
  always_comb begin
    valid_d = valid_q;
    out_d   = out_q;
    err_d   = err_q;
    ovf_d   = 1'b0;
    if (w_capture) begin
      if (!valid_q || syn_ready) begin
        out_d   = syn_in;
        err_d   = |syn_in;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && syn_ready) begin
      valid_d = 1'b0;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign syn_valid = valid_q;
  assign syn_out   = out_q;
  assign syn_err   = err_q;
  assign overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_bch_syndrome_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_bch_syndrome_capture
// Purpose  : Self-checking bench for bch_syndrome_capture (M=4, NSYN=2,
//            BEATS=15): directed scenarios followed by random traffic, all
//            compared every cycle against a beat-counting reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bch_syndrome_capture;

  localparam int M     = 4;
  localparam int NSYN  = 2;
  localparam int BEATS = 15;
  localparam int W     = NSYN * M;

  logic         clk;
  logic         reset;
  logic         start;
  logic         ce;
  logic [W-1:0] syn_in;
  logic         busy;
  logic         syn_valid;
  logic         syn_ready;
  logic [W-1:0] syn_out;
  logic         syn_err;
  logic         overflow;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int n_ovf_seen = 0;
  int n_caps     = 0;

  // Reference model: beats seen in the current codeword (-1 when none is
  // open) and whether this cycle is the capture slot after the last beat.
  int           m_beats;
  bit           m_cap_slot;
  bit           m_valid;
  logic [W-1:0] m_out;
  bit           m_err;
  bit           m_ovf;

  bch_syndrome_capture #(.M(M), .NSYN(NSYN), .BEATS(BEATS)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ce        (ce),
    .syn_in    (syn_in),
    .busy      (busy),
    .syn_valid (syn_valid),
    .syn_ready (syn_ready),
    .syn_out   (syn_out),
    .syn_err   (syn_err),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_beats    = -1;
    m_cap_slot = 1'b0;
    m_valid    = 1'b0;
    m_out      = '0;
    m_err      = 1'b0;
    m_ovf      = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs present at it.
  task automatic model_step();
    bit cap_now;
    cap_now = m_cap_slot;
    m_ovf   = 1'b0;
    if (cap_now) begin
      if (!m_valid || syn_ready) begin
        m_out   = syn_in;
        m_err   = (syn_in != 0);
        m_valid = 1'b1;
        n_caps++;
      end else begin
        m_ovf = 1'b1;
        n_ovf_seen++;
      end
    end else if (m_valid && syn_ready) begin
      m_valid = 1'b0;
    end

    if (cap_now) begin
      m_cap_slot = 1'b0;
      m_beats    = (ce && start) ? 1 : -1;
    end else if (ce) begin
      if (start) begin
        m_beats = 1;
      end else if (m_beats >= 0) begin
        m_beats++;
        if (m_beats == BEATS) begin
          m_beats    = -1;
          m_cap_slot = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".busy"},      32'(busy),      32'((m_beats >= 0) || m_cap_slot));
    chk({ph, ".syn_valid"}, 32'(syn_valid), 32'(m_valid));
    chk({ph, ".syn_out"},   32'(syn_out),   32'(m_out));
    chk({ph, ".syn_err"},   32'(syn_err),   32'(m_err));
    chk({ph, ".overflow"},  32'(overflow),  32'(m_ovf));
  endtask

  task automatic cyc(input bit s, input bit c, input logic [W-1:0] d, input string ph);
    start  = s;
    ce     = c;
    syn_in = d;
    @(posedge clk);
    model_step();
    #1;
    check_all(ph);
  endtask

  // n plain beats after a start, optionally with an idle cycle before each.
  task automatic beats(input int n, input bit gap, input string ph);
    for (int i = 0; i < n; i++) begin
      if (gap) cyc(1'b0, 1'b0, W'($urandom), ph);
      cyc(1'b0, 1'b1, W'($urandom), ph);
    end
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    ce        = 1'b0;
    syn_in    = '0;
    syn_ready = 1'b0;
    model_reset();

    // Asynchronous reset before any clock edge.
    #2 reset = 1'b1;
    #1;
    check_all("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    // Zero syndromes: clean codeword.
    cyc(1'b1, 1'b1, W'($urandom), "zero");
    beats(BEATS - 1, 1'b0, "zero");
    cyc(1'b0, 1'b0, 8'h00, "zero_cap");
    chk("zero.valid_after_cap", 32'(syn_valid), 32'd1);
    chk("zero.err_after_cap",   32'(syn_err),   32'd0);

    // Drain, then nonzero syndromes held under backpressure.
    syn_ready = 1'b1;
    cyc(1'b0, 1'b0, '0, "drain");
    syn_ready = 1'b0;
    cyc(1'b1, 1'b1, W'($urandom), "err");
    beats(BEATS - 1, 1'b0, "err");
    cyc(1'b0, 1'b0, 8'h3A, "err_cap");
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, W'($urandom), "err_hold");
    chk("err.out_held", 32'(syn_out), 32'h3A);
    chk("err.err_held", 32'(syn_err), 32'd1);
    syn_ready = 1'b1;
    cyc(1'b0, 1'b0, '0, "err_hs");
    chk("err.valid_dropped", 32'(syn_valid), 32'd0);

    // ce gated every other cycle.
    cyc(1'b1, 1'b1, W'($urandom), "gap");
    beats(BEATS - 1, 1'b1, "gap");
    cyc(1'b0, 1'b0, 8'h51, "gap_cap");

    // Back-to-back codewords with ready low: second one overflows.
    syn_ready = 1'b1;
    cyc(1'b0, 1'b0, '0, "b2b_drain");
    syn_ready = 1'b0;
    cyc(1'b1, 1'b1, W'($urandom), "b2b");
    beats(BEATS - 1, 1'b0, "b2b");
    cyc(1'b1, 1'b1, 8'hC4, "b2b_cap1");
    beats(BEATS - 1, 1'b0, "b2b");
    cyc(1'b0, 1'b0, 8'h17, "b2b_cap2");
    chk("b2b.overflow_pulse", 32'(overflow), 32'd1);
    chk("b2b.out_kept",       32'(syn_out),  32'hC4);
    cyc(1'b0, 1'b0, '0, "b2b_post");
    chk("b2b.overflow_one_cycle", 32'(overflow), 32'd0);

    // Restart at beat 7: one capture only, no overflow.
    syn_ready = 1'b1;
    cyc(1'b1, 1'b1, W'($urandom), "abort");
    beats(6, 1'b0, "abort");
    cyc(1'b1, 1'b1, W'($urandom), "abort_restart");
    beats(BEATS - 2, 1'b0, "abort");
    chk("abort.not_yet_captured", 32'(busy), 32'd1);
    cyc(1'b0, 1'b1, W'($urandom), "abort_last");
    cyc(1'b0, 1'b0, 8'h6E, "abort_cap");
    chk("abort.captured", 32'(syn_out), 32'h6E);

    // Reset at beat 10 with the buffer full.
    syn_ready = 1'b0;
    cyc(1'b1, 1'b1, W'($urandom), "rst");
    beats(9, 1'b0, "rst");
    chk("rst.valid_before", 32'(syn_valid), 32'd1);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_all("rst_async");
    @(posedge clk);
    #1 reset = 1'b0;
    check_all("rst_release");
    cyc(1'b1, 1'b1, W'($urandom), "rst_fresh");
    beats(BEATS - 1, 1'b0, "rst_fresh");
    cyc(1'b0, 1'b0, 8'h09, "rst_cap");
    chk("rst.fresh_capture", 32'(syn_out), 32'h09);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      syn_ready = ($urandom_range(0, 3) != 0);
      cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 3) == 0) ? W'(0) : W'($urandom), "rand");
    end

    chk("scenario.overflow_seen", 32'(n_ovf_seen > 0), 32'd1);
    chk("scenario.captures_seen", 32'(n_caps > 5), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
